// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and pipeline-register controls exchanged between the datapath and pipeline_ctrl.
// mem_busy is the only flow control: while it is high every enable is low and nothing is cleared.
interface pipeline_ctrl_if;
    logic [4:0] Rs1D;
    logic [4:0] Rs2D;
    logic [4:0] RdE;
    logic       LoadE;
    logic       PCSrcE;
    logic       mem_busy;
    logic       en_F;
    logic       en_D;
    logic       en_E;
    logic       flush_D;
    logic       flush_E;

    modport master (
        output Rs1D, Rs2D, RdE, LoadE, PCSrcE, mem_busy,
        input  en_F, en_D, en_E, flush_D, flush_E
    );

    modport slave (
        input  Rs1D, Rs2D, RdE, LoadE, PCSrcE, mem_busy,
        output en_F, en_D, en_E, flush_D, flush_E
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: startup flush, load-use bubble, branch flush,
// memory-wait freeze with sticky timeout, and saturating stall/flush statistics.
module pipeline_ctrl #(
    parameter int unsigned STARTUP_CYCLES = 2,
    parameter int unsigned MAX_WAIT       = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_ctrl_if.slave        bus,
    output logic [1:0]            state,
    output logic                  mem_timeout,
    output logic [31:0]           stall_cnt,
    output logic [31:0]           flush_cnt
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [3:0]  INIT_LAST  = 4'(STARTUP_CYCLES - 1);
    localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  init_cnt_q, init_cnt_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    logic en_f, en_d, en_e, flush_d, flush_e;
    logic lu;

    assign lu = bus.LoadE && (bus.RdE != 5'd0) &&
                ((bus.RdE == bus.Rs1D) || (bus.RdE == bus.Rs2D));

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        en_f        = 1'b0;
        en_d        = 1'b0;
        en_e        = 1'b0;
        flush_d     = 1'b1;
        flush_e     = 1'b1;

        case (state_q)
            ST_INIT: begin
                if (init_cnt_q >= INIT_LAST) begin
                    state_d    = ST_RUN;
                    init_cnt_d = 4'd0;
                end else begin
                    init_cnt_d = init_cnt_q + 4'd1;
                end
            end

            ST_RUN, ST_MEM_WAIT: begin
                // Priority: memory freeze, then taken branch, then load-use bubble.
                if (bus.mem_busy) begin
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                end else if (bus.PCSrcE) begin
                    en_f = 1'b1;
                    en_d = 1'b1;
                    en_e = 1'b1;
                    if (flush_cnt_q != 32'hFFFF_FFFF) flush_cnt_d = flush_cnt_q + 32'd1;
                end else if (lu) begin
                    en_e    = 1'b1;
                    flush_d = 1'b0;
                end else begin
                    en_f    = 1'b1;
                    en_d    = 1'b1;
                    en_e    = 1'b1;
                    flush_d = 1'b0;
                    flush_e = 1'b0;
                end

                state_d = bus.mem_busy ? ST_MEM_WAIT : ST_RUN;

                if (bus.mem_busy) begin
                    if (wait_cnt_q != 16'hFFFF) wait_cnt_d = wait_cnt_q + 16'd1;
                    if (wait_cnt_d >= MAX_WAIT_W) timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = 16'd0;
                end

                if (!en_f && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
            end

            default: begin
                state_d    = ST_INIT;
                init_cnt_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= 4'd0;
            wait_cnt_q  <= 16'd0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign bus.en_F    = en_f;
    assign bus.en_D    = en_d;
    assign bus.en_E    = en_e;
    assign bus.flush_D = flush_d;
    assign bus.flush_E = flush_e;

    assign state       = state_q;
    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter STARTUP_CYCLES, default 2: cycles of front-end flush after reset release, range 1..15.
REQ-002 Parameter MAX_WAIT, default 255: consecutive mem_busy cycles before timeout, range 1..65535.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 Rs1D  input  5  rs1 of the instruction in ID.
REQ-006 Rs2D  input  5  rs2 of the instruction in ID.
REQ-007 RdE  input  5  destination register of the instruction in EX.
REQ-008 LoadE  input  1  EX instruction is a load.
REQ-009 PCSrcE  input  1  branch/jump taken, resolved in EX.
REQ-010 mem_busy  input  1  data memory not ready; whole pipeline must hold.
REQ-011 en_F  output  1  PC register enable, high = advance.
REQ-012 en_D  output  1  IF/ID register enable.
REQ-013 en_E  output  1  ID/EX and later pipeline register enable.
REQ-014 flush_D  output  1  IF/ID synchronous clear.
REQ-015 flush_E  output  1  ID/EX synchronous clear.
REQ-016 state  output  2  FSM state: 0 INIT, 1 RUN, 2 MEM_WAIT.
REQ-017 mem_timeout  output  1  sticky error flag.
REQ-018 stall_cnt  output  32  cycles with en_F=0 outside INIT, saturating.
REQ-019 flush_cnt  output  32  taken-branch flushes, saturating.

Function
REQ-020 Load-use hazard (lu) SHALL be LoadE & (RdE!=0) & (RdE==Rs1D | RdE==Rs2D).
REQ-021 INIT: en_F=en_D=en_E=0, flush_D=flush_E=1; a 4-bit counter SHALL count STARTUP_CYCLES cycles, then go to RUN.
REQ-022 RUN/MEM_WAIT outputs SHALL be combinational from current inputs, priority mem_busy > PCSrcE > lu > normal.
REQ-023 mem_busy=1: en_F=en_D=en_E=0, flush_D=flush_E=0 (full freeze, nothing lost).
REQ-024 PCSrcE=1 (mem_busy=0): en_F=en_D=en_E=1, flush_D=flush_E=1; flush_cnt +1.
REQ-025 lu=1 (mem_busy=0, PCSrcE=0): en_F=en_D=0, en_E=1, flush_E=1, flush_D=0 (one bubble).
REQ-026 Normal: en_F=en_D=en_E=1, flush_D=flush_E=0.
REQ-027 RUN -> MEM_WAIT when mem_busy=1; MEM_WAIT -> RUN the edge after mem_busy=0, with the REQ-022 decision applied combinationally in that mem_busy=0 cycle.
REQ-028 A 16-bit wait counter SHALL count consecutive mem_busy=1 cycles and clear when mem_busy=0; on reaching MAX_WAIT, mem_timeout SHALL set and hold until reset; freeze continues.
REQ-029 stall_cnt SHALL increment each cycle en_F=0 in RUN or MEM_WAIT; both counters SHALL saturate at 0xFFFFFFFF.
REQ-030 Flush and enable both high on the same register: flush SHALL take effect (register convention).
REQ-031 Inputs in INIT SHALL be ignored, including mem_busy and PCSrcE.

Reset
REQ-032 rst=1 SHALL immediately force state=INIT, INIT and wait counters=0, stall_cnt=flush_cnt=0, mem_timeout=0, outputs per REQ-021.
REQ-033 rst asserted mid-MEM_WAIT or mid-stall SHALL abort it with no pending effect after release.

Verification
REQ-034 Reset release, idle inputs -> flush_D=flush_E=1 for exactly 2 cycles, then state=1 and all enables 1.
REQ-035 LoadE=1, RdE=5, Rs2D=5 one cycle -> en_F=en_D=0, flush_E=1 that cycle; stall_cnt=1; RdE=0 same case -> no stall.
REQ-036 PCSrcE=1 together with lu -> flush_D=flush_E=1, en_F=1, flush_cnt=1, stall_cnt unchanged.
REQ-037 mem_busy high 3 cycles with PCSrcE=1 -> freeze 3 cycles, state=2, then flush on the first cycle mem_busy=0; stall_cnt=3.
REQ-038 MAX_WAIT=4, mem_busy held 6 cycles -> mem_timeout rises on the 4th busy cycle, stays 1 after mem_busy drops until rst.
REQ-039 rst pulsed during MEM_WAIT -> state=0 asynchronously, counters 0, INIT sequence repeats.
